// File: rtl/fpga_test_pkg.sv
// Shared types and default parameters for the FPGA test-program runner.
package fpga_test_pkg;

   localparam int DEF_RUNS         = 4;
   localparam int DEF_TIMEOUT      = 1000;
   localparam int DEF_RESET_CYCLES = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET_DUT,
      S_RUN,
      S_RECORD,
      S_DONE
   } runner_state_t;

   typedef enum logic [1:0] {
      OUT_PASS,
      OUT_FAIL,
      OUT_TIMEOUT
   } outcome_t;

endpackage

// File: rtl/fpga_timeout_counter.sv
// Clearable up-counter that saturates at term_i and flags the terminal count.
module fpga_timeout_counter #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear_i,
   input  logic         inc_i,
   input  logic [W-1:0] term_i,
   output logic [W-1:0] count_o,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != term_i)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;
   assign tc_o    = (cnt_q == term_i);

endmodule

// File: rtl/fpga_test_runner.sv
// Repeats a reset/run/record cycle on the program module RUNS times and tallies
// pass, fail and timeout outcomes.
module fpga_test_runner
   import fpga_test_pkg::*;
#(
   parameter int  RUNS         = DEF_RUNS,
   parameter int  TIMEOUT      = DEF_TIMEOUT,
   parameter int  RESET_CYCLES = DEF_RESET_CYCLES,
   localparam int CW           = $clog2(RUNS + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   output logic          dut_reset,
   input  logic          dut_finished,
   input  logic          dut_success,
   output logic          busy,
   output logic          done,
   output logic          all_passed,
   output logic [CW-1:0] pass_count,
   output logic [CW-1:0] fail_count,
   output logic [CW-1:0] timeout_count
);

   // One counter serves both the reset hold and the run timeout, so it is
   // sized for whichever terminal count is larger.
   localparam int TW  = $clog2(TIMEOUT);
   localparam int RW  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int CTW = (TW > RW) ? TW : RW;
   localparam logic [CTW-1:0] RST_TERM = CTW'(RESET_CYCLES - 1);
   localparam logic [CTW-1:0] RUN_TERM = CTW'(TIMEOUT - 1);

   runner_state_t state_q, state_d;
   outcome_t      outcome_q, outcome_d;
   logic [CW-1:0] pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d, idx_q, idx_d;
   logic          dut_reset_q;

   logic           ctr_clr, ctr_inc, ctr_tc;
   logic [CTW-1:0] ctr_term, ctr_cnt;

   fpga_timeout_counter #(.W(CTW)) u_ctr (
      .clock   (clock),
      .reset   (reset),
      .clear_i (ctr_clr),
      .inc_i   (ctr_inc),
      .term_i  (ctr_term),
      .count_o (ctr_cnt),
      .tc_o    (ctr_tc)
   );

   always_comb begin
      state_d   = state_q;
      outcome_d = outcome_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      tmo_d     = tmo_q;
      idx_d     = idx_q;
      ctr_clr   = 1'b0;
      ctr_inc   = 1'b0;
      ctr_term  = RST_TERM;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               pass_d  = '0;
               fail_d  = '0;
               tmo_d   = '0;
               idx_d   = '0;
               ctr_clr = 1'b1;
               state_d = S_RESET_DUT;
            end
         end
         S_RESET_DUT: begin
            if (ctr_tc) begin
               ctr_clr = 1'b1;
               state_d = S_RUN;
            end else begin
               ctr_inc = 1'b1;
            end
         end
         S_RUN: begin
            ctr_term = RUN_TERM;
            ctr_inc  = 1'b1;
            // The first RUN cycle (count 0) ignores a finished flag left over from before reset.
            if (dut_finished && (ctr_cnt != '0)) begin
               outcome_d = dut_success ? OUT_PASS : OUT_FAIL;
               state_d   = S_RECORD;
            end else if (ctr_tc) begin
               outcome_d = OUT_TIMEOUT;
               state_d   = S_RECORD;
            end
         end
         S_RECORD: begin
            case (outcome_q)
               OUT_PASS: pass_d = pass_q + 1'b1;
               OUT_FAIL: fail_d = fail_q + 1'b1;
               default:  tmo_d  = tmo_q + 1'b1;
            endcase
            idx_d   = idx_q + 1'b1;
            ctr_clr = 1'b1;
            state_d = (idx_q == CW'(RUNS - 1)) ? S_DONE : S_RESET_DUT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         outcome_q   <= OUT_PASS;
         pass_q      <= '0;
         fail_q      <= '0;
         tmo_q       <= '0;
         idx_q       <= '0;
         dut_reset_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         outcome_q   <= outcome_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         tmo_q       <= tmo_d;
         idx_q       <= idx_d;
         dut_reset_q <= (state_d != S_RUN);
      end
   end

   assign dut_reset     = dut_reset_q;
   assign busy          = (state_q == S_RESET_DUT) || (state_q == S_RUN) || (state_q == S_RECORD);
   assign done          = (state_q == S_DONE);
   assign all_passed    = done && (pass_q == CW'(RUNS));
   assign pass_count    = pass_q;
   assign fail_count    = fail_q;
   assign timeout_count = tmo_q;

endmodule

// File: tb/tb_fpga_test_runner.sv
// Self-checking bench: a behavioural program-module stand-in plus per-run outcome model.
module tb_fpga_test_runner;

   localparam int RUNS         = 4;
   localparam int TIMEOUT      = 50;
   localparam int RESET_CYCLES = 2;
   localparam int CW           = $clog2(RUNS + 1);
   localparam int BUDGET       = 400;

   typedef struct packed {
      logic [3:0][7:0] fin;    // RUN cycle (1-based) where finished rises; 0 = never
      logic [3:0]      succ;
      logic [3:0]      stale;  // finished held high through the reset phase
      int              exp_pass;
      int              exp_fail;
      int              exp_tmo;
      bit              exp_all;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          dut_reset;
   logic          dut_finished;
   logic          dut_success;
   logic          busy, done, all_passed;
   logic [CW-1:0] pass_count, fail_count, timeout_count;

   int checks = 0;
   int errors = 0;

   int sc_fin[RUNS];
   bit sc_succ[RUNS];
   bit sc_stale[RUNS];
   int epoch = 0;

   int seen_epoch = 0;
   int rc = 0;
   int hi_cnt = 0;
   int run_no = 0;
   int low_q[$];
   int hi_q[$];

   vec_t tbl[5];

   always #5 clk = ~clk;

   fpga_test_runner #(
      .RUNS         (RUNS),
      .TIMEOUT      (TIMEOUT),
      .RESET_CYCLES (RESET_CYCLES)
   ) dut (
      .clock         (clk),
      .reset         (rst_n),
      .start         (start),
      .dut_reset     (dut_reset),
      .dut_finished  (dut_finished),
      .dut_success   (dut_success),
      .busy          (busy),
      .done          (done),
      .all_passed    (all_passed),
      .pass_count    (pass_count),
      .fail_count    (fail_count),
      .timeout_count (timeout_count)
   );

   // Program-module stand-in and reset-phase monitor, active on the falling edge.
   always @(negedge clk) begin : prog_model
      bit fin_now;
      bit succ_now;
      if (epoch != seen_epoch) begin
         seen_epoch = epoch;
         rc = 0;
         hi_cnt = 0;
         run_no = 0;
         low_q.delete();
         hi_q.delete();
      end
      fin_now = 1'b0;
      succ_now = 1'b0;
      if (!dut_reset) begin
         if (rc == 0) begin
            if (run_no > 0) hi_q.push_back(hi_cnt);
            run_no++;
         end
         rc++;
         hi_cnt = 0;
         if (run_no <= RUNS) begin
            fin_now = (rc == 1 && sc_stale[run_no-1]) ||
                      (sc_fin[run_no-1] != 0 && rc >= sc_fin[run_no-1]);
            succ_now = sc_succ[run_no-1];
         end
      end else begin
         if (rc != 0) low_q.push_back(rc);
         rc = 0;
         hi_cnt++;
         if (run_no < RUNS) begin
            fin_now = sc_stale[run_no];
            succ_now = sc_succ[run_no];
         end
      end
      dut_finished = fin_now;
      dut_success = succ_now;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Outcome of one run: 0 pass, 1 fail, 2 timeout; len = RUN cycles spent.
   // Cycle 1 is blind, so a visible finish lands on max(fin,2) if within TIMEOUT.
   function automatic void ref_run(input int fin, input bit succ, output int outc, output int len);
      if (fin != 0 && fin <= TIMEOUT) begin
         outc = succ ? 0 : 1;
         len  = (fin < 2) ? 2 : fin;
      end else begin
         outc = 2;
         len  = TIMEOUT;
      end
   endfunction

   function automatic vec_t mkv(input int f0, input int f1, input int f2, input int f3,
                                input logic [3:0] su, input logic [3:0] st,
                                input int p, input int f, input int t, input bit a);
      vec_t v;
      v.fin      = {8'(f3), 8'(f2), 8'(f1), 8'(f0)};
      v.succ     = su;
      v.stale    = st;
      v.exp_pass = p;
      v.exp_fail = f;
      v.exp_tmo  = t;
      v.exp_all  = a;
      return v;
   endfunction

   task automatic load_scn(input vec_t v);
      for (int r = 0; r < RUNS; r++) begin
         sc_fin[r]   = int'(v.fin[r]);
         sc_succ[r]  = v.succ[r];
         sc_stale[r] = v.stale[r];
      end
      epoch++;
   endtask

   // Caller is aligned 1 time unit after a posedge.
   task automatic run_batch(input string tag, input vec_t v, input bit mid_start);
      int cyc;
      bit pulsed;
      int outc, len;
      load_scn(v);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, " busy after start"}, int'(busy), 1);
      check({tag, " done cleared"}, int'(done), 0);
      check({tag, " pass cleared"}, int'(pass_count), 0);
      cyc = 0;
      pulsed = 1'b0;
      while (!done && cyc < BUDGET) begin
         @(posedge clk); #1;
         cyc++;
         start = 1'b0;
         if (mid_start && !pulsed && run_no == 2 && rc >= 3 && !dut_reset) begin
            start = 1'b1;
            pulsed = 1'b1;
         end
      end
      start = 1'b0;
      check({tag, " done reached"}, int'(done), 1);
      if (mid_start) check({tag, " mid-run start issued"}, int'(pulsed), 1);
      check({tag, " pass_count"}, int'(pass_count), v.exp_pass);
      check({tag, " fail_count"}, int'(fail_count), v.exp_fail);
      check({tag, " timeout_count"}, int'(timeout_count), v.exp_tmo);
      check({tag, " all_passed"}, int'(all_passed), int'(v.exp_all));
      check({tag, " busy in done"}, int'(busy), 0);
      check({tag, " dut_reset in done"}, int'(dut_reset), 1);
      check({tag, " runs observed"}, low_q.size(), RUNS);
      for (int r = 0; r < RUNS && r < low_q.size(); r++) begin
         ref_run(int'(v.fin[r]), v.succ[r], outc, len);
         check($sformatf("%s run%0d length", tag, r), low_q[r], len);
      end
      check({tag, " reset gaps"}, hi_q.size(), RUNS - 1);
      foreach (hi_q[i]) check($sformatf("%s gap%0d", tag, i), hi_q[i], RESET_CYCLES + 1);
      repeat (3) @(posedge clk);
      #1;
      check({tag, " done held"}, int'(done), 1);
      check({tag, " pass held"}, int'(pass_count), v.exp_pass);
   endtask

   initial begin
      vec_t rv;
      int outc, len, cyc;
      for (int r = 0; r < RUNS; r++) begin
         sc_fin[r] = 0;
         sc_succ[r] = 1'b0;
         sc_stale[r] = 1'b0;
      end
      tbl[0] = mkv(10, 10, 10, 10, 4'b1111, 4'b0000, 4, 0, 0, 1'b1);
      tbl[1] = mkv(10, 10, 10, 10, 4'b1011, 4'b0000, 3, 1, 0, 1'b0);
      tbl[2] = mkv(10,  0, 10, 10, 4'b1111, 4'b0000, 3, 0, 1, 1'b0);
      tbl[3] = mkv(50, 51,  2, 10, 4'b0111, 4'b0000, 2, 1, 1, 1'b0);
      tbl[4] = mkv( 2,  0,  3, 10, 4'b1011, 4'b0111, 2, 1, 1, 1'b0);

      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset dut_reset", int'(dut_reset), 1);
      check("reset busy", int'(busy), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check($sformatf("idle outputs cycle%0d", i),
               int'({dut_reset, busy, done, all_passed, pass_count, fail_count, timeout_count}),
               int'({1'b1, 3'b000, 9'd0}));
      end

      for (int i = 0; i < 5; i++) run_batch($sformatf("tbl%0d", i), tbl[i], 1'b0);

      run_batch("midstart", tbl[2], 1'b1);

      load_scn(tbl[0]);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (!(run_no == 2 && rc >= 3) && cyc < BUDGET) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("abort reached run2", int'(run_no == 2 && rc >= 3), 1);
      check("abort pass before reset", int'(pass_count), 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("abort dut_reset", int'(dut_reset), 1);
      check("abort busy", int'(busy), 0);
      check("abort done", int'(done), 0);
      check("abort all_passed", int'(all_passed), 0);
      check("abort counts", int'({pass_count, fail_count, timeout_count}), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort still idle", int'({busy, done}), 0);
      run_batch("after abort", tbl[0], 1'b0);

      for (int b = 0; b < 6; b++) begin
         rv = '0;
         for (int r = 0; r < RUNS; r++) begin
            case ($urandom_range(0, 7))
               0:       rv.fin[r] = 8'd0;
               1:       rv.fin[r] = 8'($urandom_range(TIMEOUT - 1, TIMEOUT + 1));
               default: rv.fin[r] = 8'($urandom_range(1, TIMEOUT - 2));
            endcase
            rv.succ[r]  = 1'($urandom_range(0, 1));
            rv.stale[r] = ($urandom_range(0, 3) == 0);
            ref_run(int'(rv.fin[r]), rv.succ[r], outc, len);
            if (outc == 0) rv.exp_pass++;
            else if (outc == 1) rv.exp_fail++;
            else rv.exp_tmo++;
         end
         rv.exp_all = (rv.exp_pass == RUNS);
         run_batch($sformatf("rand%0d", b), rv, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpga_test_runner.md
Name: fpga_test_runner

Overview:
- Upstream harness for the fpga test-program module: drives that module's active-high reset, waits for its finished flag, samples success, and repeats for a fixed number of runs.
- Tallies passes, fails and timeouts, then raises done/all_passed for board LEDs or the top-level bench.
- Turns a single-shot program run into a bounded, repeatable regression on the FPGA.

Parameters:
- RUNS, 4, number of program runs per start request (>=1).
- TIMEOUT, 1000, maximum clock cycles in RUN before a run is declared timed out (>=2).
- RESET_CYCLES, 2, cycles dut_reset is held high before each run (>=1).
- CW, $clog2(RUNS+1), width of the run/pass/fail/timeout counters (derived, not overridden).

Ports:
- clock  input  1  single system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset: asserted when low, released when high.
- start  input  1  one-cycle request to begin a batch; ignored while busy.
- dut_reset  output  1  active-high reset to the program module.
- dut_finished  input  1  program module finished flag (level).
- dut_success  input  1  program module success flag (level, valid when dut_finished=1).
- busy  output  1  high from accepted start until DONE.
- done  output  1  high in DONE, held until next accepted start.
- all_passed  output  1  high in DONE iff pass_count==RUNS.
- pass_count  output  CW  runs finishing with success=1.
- fail_count  output  CW  runs finishing with success=0.
- timeout_count  output  CW  runs with no finished within TIMEOUT.

Behaviour:
- Reset values (reset low, asynchronous):
  - state=IDLE; dut_reset=1, so the program module is held in reset.
  - busy=0, done=0, all_passed=0.
  - all counters and the internal run index = 0.
- States: IDLE, RESET_DUT, RUN, RECORD, DONE.
- IDLE:
  - dut_reset=1.
  - start=1 -> clear all counts and run index, load reset counter with RESET_CYCLES, go to RESET_DUT; busy=1 next cycle.
- RESET_DUT:
  - dut_reset=1 for exactly RESET_CYCLES cycles.
  - Then go to RUN with cycle counter=0; dut_reset=0 from the first RUN cycle.
- RUN:
  - dut_reset=0; cycle counter increments each cycle.
  - dut_finished is blanked on the first RUN cycle (stale-flag protection) and sampled from the second RUN cycle on.
  - Sampled dut_finished=1 -> latch dut_success, go to RECORD.
  - Counter reaches TIMEOUT-1 without a sampled finished -> mark timeout, go to RECORD.
  - Finished and timeout in the same cycle: finished wins and is recorded as pass/fail, not timeout.
- RECORD (1 cycle):
  - dut_reset=1.
  - Increment exactly one of pass_count/fail_count/timeout_count; increment run index.
  - Run index reaches RUNS -> DONE; else reload reset counter -> RESET_DUT.
  - Invariant: pass+fail+timeout == run index, at all times.
- DONE:
  - busy=0, done=1, dut_reset=1; all_passed = (pass_count==RUNS).
  - Counts held stable.
  - start=1 -> clear counts/done/all_passed, go to RESET_DUT (same as IDLE start).
- start while busy (RESET_DUT/RUN/RECORD): ignored, no effect on counts.
- dut_success is ignored unless dut_finished is sampled high in RUN.
- Mid-batch reset: immediate return to reset values. The partially completed batch is discarded; no counter retains its value.
- Clocking:
  - The program module may act on both clock edges.
  - The runner samples only on posedge; dut_finished/dut_success must be stable across a full cycle.
  - dut_reset is registered (glitch-free).
- Counter widths: CW bits suffice for RUNS; no wrap is possible.
- The cycle counter is $clog2(TIMEOUT) bits wide and saturates; it never wraps within a run.

Decomposition:
- Package fpga_test_pkg:
  - runner_state_t enum (IDLE, RESET_DUT, RUN, RECORD, DONE).
  - default constants DEF_RUNS, DEF_TIMEOUT, DEF_RESET_CYCLES.
  - outcome_t enum (PASS, FAIL, TIMEOUT) used by RECORD.
- One sub-module: fpga_timeout_counter.
  - Loadable/clearable cycle counter with terminal-count output.
  - Reused for both the RESET_DUT hold count and the RUN timeout count.
- The FSM and tally registers stay in fpga_test_runner.

Test Plan:
- Reset low then high, no start for 20 cycles:
  - dut_reset=1, busy=0, done=0, all counts 0 throughout.
- RUNS=4, RESET_CYCLES=2; start pulse; model finishes 10 cycles after dut_reset falls with success=1 every run:
  - dut_reset high exactly 2 cycles before each run.
  - pass_count=4, fail=0, timeout=0, done=1, all_passed=1.
- Same setup, model returns success=0 on run 3:
  - pass=3, fail=1, timeout=0, all_passed=0.
- TIMEOUT=50, model never finishes on run 2:
  - Run 2 ends after 50 RUN cycles; timeout_count=1, pass=3.
  - Model finished=1 first appearing on cycle 49 (final cycle) of another run -> counted as pass, not timeout.
- Model holds finished=1 through reset release:
  - First RUN cycle ignored; recorded only if finished still high on the second RUN cycle.
  - start pulsed mid-RUN -> no restart, counts unchanged.
- Reset driven low during run 2 of a batch:
  - All outputs return to reset values immediately, dut_reset=1.
  - A subsequent start yields a fresh 4-run batch with correct counts.
